// File: rtl/pulse_width_meas.sv
// -----------------------------------------------------------------------------
// pulse_width_meas
//   Measures every high pulse of a single-bit, clk-synchronous signal in clock
//   cycles. Each completed pulse is reported with a one-cycle strobe, a
//   saturation flag and a wrapping count of completed pulses.
//
//   Optional feature macro: PULSE_MEAS_GAP_EN
//     When defined, low gaps between a fall and the next rise are also
//     measured and reported on gap_o/gap_vld_o. When undefined, those outputs
//     are tied to 0 and no gap counter is built.
//
// Parameters
//   CNT_W   width of width/gap counters and results (>= 2)
//   PCNT_W  width of the completed-pulse counter
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   signal_i     measured signal (synchronous to clk)
//   width_o      last measured high width in cycles
//   width_vld_o  one-cycle strobe, width_o/ovf_o updated
//   ovf_o        last width saturated at 2^CNT_W-1
//   pulse_cnt_o  completed pulses since reset, wraps
//   busy_o       high while a high pulse is being measured
//   gap_o        last low gap width (gap feature only)
//   gap_vld_o    one-cycle strobe for gap_o (gap feature only)
// -----------------------------------------------------------------------------
module pulse_width_meas #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signal_i,
    output logic [CNT_W-1:0]  width_o,
    output logic              width_vld_o,
    output logic              ovf_o,
    output logic [PCNT_W-1:0] pulse_cnt_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  gap_o,
    output logic              gap_vld_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t           state;
    logic             sig_q;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;

    assign rise = signal_i & ~sig_q;
    assign fall = ~signal_i & sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ARM;
            sig_q       <= 1'b0;
            cnt         <= '0;
            width_o     <= '0;
            width_vld_o <= 1'b0;
            ovf_o       <= 1'b0;
            pulse_cnt_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            sig_q       <= signal_i;
            width_vld_o <= 1'b0;
            case (state)
                // A pulse already high when reset releases is never reported:
                // wait for a genuine low sample first.
                ST_ARM: begin
                    if (!signal_i) state <= ST_LOW;
                end
                ST_LOW: begin
                    if (rise) begin
                        state  <= ST_HIGH;
                        cnt    <= CNT_W'(1);
                        busy_o <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state       <= ST_LOW;
                        width_o     <= cnt;
                        ovf_o       <= (cnt == CNT_MAX);
                        width_vld_o <= 1'b1;
                        pulse_cnt_o <= pulse_cnt_o + PCNT_W'(1);
                        busy_o      <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        // saturate rather than wrap on very long pulses
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

`ifdef PULSE_MEAS_GAP_EN
    logic [CNT_W-1:0] gcnt;
    logic             gap_armed;

    // The fall sample is itself the first low sample of the gap, so the gap
    // counter starts at 1 there. No gap is reported before the first fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt      <= '0;
            gap_armed <= 1'b0;
            gap_o     <= '0;
            gap_vld_o <= 1'b0;
        end else begin
            gap_vld_o <= 1'b0;
            if (state == ST_HIGH && fall) begin
                gap_armed <= 1'b1;
                gcnt      <= CNT_W'(1);
            end else if (state == ST_LOW && gap_armed) begin
                if (rise) begin
                    gap_o     <= gcnt;
                    gap_vld_o <= 1'b1;
                end else if (gcnt != CNT_MAX) begin
                    gcnt <= gcnt + CNT_W'(1);
                end
            end
        end
    end
`else
    assign gap_o     = '0;
    assign gap_vld_o = 1'b0;
`endif

endmodule
